rv32_hart_scheduler: RTL and testbench

RV32_HART_SCHEDULER -- requirements
Module: rv32_hart_scheduler

---
 rtl/rv32_hart_scheduler.sv | 140 ++++++++++++++
 tb/tb_rv32_hart_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_hart_scheduler.sv
// Round-robin hart issue scheduler with per-hart block/park tracking.
// Define RV32_SCHED_PERF_EN to add the perf_issue_cnt/perf_idle_cnt counters.
module rv32_hart_scheduler #(
  parameter int NUM_HARTS = 8,
  parameter int HART_ID_W = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [HART_ID_W-1:0] issue_hart,
  input  logic                 block_set,
  input  logic [HART_ID_W-1:0] block_set_hart,
  input  logic                 block_clr,
  input  logic [HART_ID_W-1:0] block_clr_hart,
  input  logic                 trap_valid,
  input  logic [HART_ID_W-1:0] trap_hart,
  input  logic [NUM_HARTS-1:0] resume,
  output logic [NUM_HARTS-1:0] hart_blocked,
  output logic [NUM_HARTS-1:0] hart_parked,
  output logic                 sched_idle
`ifdef RV32_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_issue_cnt,
  output logic [31:0]          perf_idle_cnt
`endif
);

  // state  | meaning
  // IDLE   | no hart offered, waiting for an eligible hart
  // OFFER  | issue_hart offered to fetch, held until issue_ready
  typedef enum logic {ST_IDLE = 1'b0, ST_OFFER = 1'b1} state_t;

  state_t                 state_q;
  logic                   valid_q;
  logic [HART_ID_W-1:0]   hart_q;
  logic [HART_ID_W-1:0]   rr_q;
  logic [NUM_HARTS-1:0]   blocked_q, blocked_d;
  logic [NUM_HARTS-1:0]   parked_q, parked_d;
  logic [NUM_HARTS-1:0]   set_mask, clr_mask, trap_mask;
  logic [NUM_HARTS-1:0]   elig;
  logic                   any_elig;
  logic [HART_ID_W-1:0]   pick_base;
  logic [HART_ID_W-1:0]   next_hart_d;

  function automatic logic [HART_ID_W-1:0] pick(input logic [HART_ID_W-1:0] p,
                                                input logic [NUM_HARTS-1:0] el);
    logic                 found;
    logic [HART_ID_W-1:0] idx;
    pick  = p;
    found = 1'b0;
    // Offset NUM_HARTS wraps back to p, so p wins only when nothing else is eligible.
    for (int k = 1; k <= NUM_HARTS; k++) begin
      idx = p + HART_ID_W'(k);
      if (!found && el[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    set_mask    = block_set  ? (NUM_HARTS'(1) << block_set_hart) : '0;
    clr_mask    = block_clr  ? (NUM_HARTS'(1) << block_clr_hart) : '0;
    trap_mask   = trap_valid ? (NUM_HARTS'(1) << trap_hart)      : '0;
    blocked_d   = (blocked_q & ~clr_mask) | set_mask;
    parked_d    = (parked_q & ~resume) | trap_mask;
    // Same-cycle block/trap already disqualify; clear/resume take effect next cycle.
    elig        = hart_en & ~blocked_q & ~parked_q & ~set_mask & ~trap_mask;
    any_elig    = |elig;
    pick_base   = (state_q == ST_OFFER) ? hart_q : rr_q;
    next_hart_d = pick(pick_base, elig);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      hart_q  <= '0;
      rr_q    <= HART_ID_W'(NUM_HARTS - 1);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_elig) begin
            state_q <= ST_OFFER;
            valid_q <= 1'b1;
            hart_q  <= next_hart_d;
          end
        end
        ST_OFFER: begin
          if (issue_ready) begin
            rr_q <= hart_q;
            if (any_elig) begin
              hart_q <= next_hart_d;
            end else begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blocked_q <= '0;
      parked_q  <= '0;
    end else begin
      blocked_q <= blocked_d;
      parked_q  <= parked_d;
    end
  end

  assign issue_valid  = valid_q;
  assign issue_hart   = hart_q;
  assign hart_blocked = blocked_q;
  assign hart_parked  = parked_q;
  assign sched_idle   = (state_q == ST_IDLE);

`ifdef RV32_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt <= '0;
      perf_idle_cnt  <= '0;
    end else begin
      if (valid_q && issue_ready) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (state_q == ST_IDLE)     perf_idle_cnt  <= perf_idle_cnt + 32'd1;
    end
  end
`else
  // Counters compiled out; the handshake and idle decode feed only the FSM.
`endif

endmodule

// File: tb/tb_rv32_hart_scheduler.sv
// Bench for rv32_hart_scheduler: vector table, directed corner sequences and
// randomized traffic against an array-based reference model.
module tb_rv32_hart_scheduler;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] hart_en = '0;
  logic         issue_ready = 1'b0;
  logic         issue_valid;
  logic [W-1:0] issue_hart;
  logic         block_set = 1'b0;
  logic [W-1:0] block_set_hart = '0;
  logic         block_clr = 1'b0;
  logic [W-1:0] block_clr_hart = '0;
  logic         trap_valid = 1'b0;
  logic [W-1:0] trap_hart = '0;
  logic [N-1:0] resume = '0;
  logic [N-1:0] hart_blocked;
  logic [N-1:0] hart_parked;
  logic         sched_idle;

  rv32_hart_scheduler #(.NUM_HARTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .hart_en(hart_en), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_hart(issue_hart),
    .block_set(block_set), .block_set_hart(block_set_hart),
    .block_clr(block_clr), .block_clr_hart(block_clr_hart),
    .trap_valid(trap_valid), .trap_hart(trap_hart), .resume(resume),
    .hart_blocked(hart_blocked), .hart_parked(hart_parked), .sched_idle(sched_idle)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: offer flag, offered hart, round-robin pointer, per-hart flags.
  bit m_valid;
  int m_hart;
  int m_rr;
  bit m_blk[N];
  bit m_prk[N];

  typedef struct {
    logic [N-1:0] en;
    logic         rdy;
    logic         exp_valid;
    int           exp_hart;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_pick(input int p, input bit el[N]);
    for (int k = 1; k <= N; k++) begin
      if (el[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  function automatic int pack(input bit a[N]);
    int r = 0;
    for (int i = 0; i < N; i++) if (a[i]) r = r | (1 << i);
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_hart  = 0;
    m_rr    = N - 1;
    for (int i = 0; i < N; i++) begin
      m_blk[i] = 1'b0;
      m_prk[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit el[N];
    bit any = 1'b0;
    for (int i = 0; i < N; i++) begin
      el[i] = hart_en[i] && !m_blk[i] && !m_prk[i] &&
              !(block_set && int'(block_set_hart) == i) &&
              !(trap_valid && int'(trap_hart) == i);
      any = any | el[i];
    end
    if (!m_valid) begin
      if (any) begin
        m_valid = 1'b1;
        m_hart  = model_pick(m_rr, el);
      end
    end else if (issue_ready) begin
      m_rr = m_hart;
      if (any) m_hart = model_pick(m_hart, el);
      else     m_valid = 1'b0;
    end
    if (block_clr) m_blk[block_clr_hart] = 1'b0;
    if (block_set) m_blk[block_set_hart] = 1'b1;
    for (int i = 0; i < N; i++) if (resume[i]) m_prk[i] = 1'b0;
    if (trap_valid) m_prk[trap_hart] = 1'b1;
  endtask

  task automatic compare_model();
    check("model_valid",   int'(issue_valid),  int'(m_valid));
    check("model_hart",    int'(issue_hart),   m_hart);
    check("model_idle",    int'(sched_idle),   int'(!m_valid));
    check("model_blocked", int'(hart_blocked), pack(m_blk));
    check("model_parked",  int'(hart_parked),  pack(m_prk));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic clear_pulses();
    block_set  = 1'b0;
    block_clr  = 1'b0;
    trap_valid = 1'b0;
    resume     = '0;
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 9; i++)   vecs[i] = '{8'hFF, 1'b1, 1'b1, (i == 8) ? 0 : i};
    for (int i = 9; i < 13; i++)  vecs[i] = '{8'h24, 1'b1, 1'b1, (i % 2 == 1) ? 2 : 5};
    for (int i = 13; i < 16; i++) vecs[i] = '{8'h08, 1'b1, 1'b1, 3};
    vecs[16] = '{8'h00, 1'b1, 1'b0, 3};
    vecs[17] = '{8'h00, 1'b1, 1'b0, 3};
    vecs[18] = '{8'h10, 1'b0, 1'b1, 4};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_model();
    rst_n = 1'b1;

    // Round-robin patterns from reset release
    for (int i = 0; i < 19; i++) begin
      hart_en     = vecs[i].en;
      issue_ready = vecs[i].rdy;
      cycle();
      check("vec_valid", int'(issue_valid), int'(vecs[i].exp_valid));
      check("vec_hart",  int'(issue_hart),  vecs[i].exp_hart);
    end

    // Stalled offer of hart 4, trapped during the stall
    hart_en = 8'hFF;
    issue_ready = 1'b0;
    trap_valid = 1'b1;
    trap_hart = 3'd4;
    cycle();
    clear_pulses();
    check("stall_hart", int'(issue_hart), 4);
    check("stall_parked4", int'(hart_parked[4]), 1);
    repeat (2) cycle();
    check("stall_hold", int'(issue_hart), 4);
    check("stall_valid", int'(issue_valid), 1);
    issue_ready = 1'b1;
    cycle();
    check("post_trap_next", int'(issue_hart), 5);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (issue_valid && issue_hart == 3'd4) seen++;
    end
    check("parked_not_offered", seen, 0);
    resume = 8'h10;
    cycle();
    clear_pulses();
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (issue_valid && issue_hart == 3'd4) seen = 1;
    end
    check("resumed_offered", seen, 1);

    // Block set and clear collide on hart 1
    block_set = 1'b1; block_set_hart = 3'd1;
    block_clr = 1'b1; block_clr_hart = 3'd1;
    cycle();
    clear_pulses();
    check("set_wins", int'(hart_blocked[1]), 1);
    block_clr = 1'b1; block_clr_hart = 3'd1;
    cycle();
    clear_pulses();
    check("clr_alone", int'(hart_blocked[1]), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (issue_valid && issue_hart == 3'd1) seen = 1;
    end
    check("hart1_eligible", seen, 1);

    // Block every hart, then release hart 6
    for (int i = 0; i < N; i++) begin
      block_set = 1'b1;
      block_set_hart = W'(i);
      cycle();
    end
    clear_pulses();
    repeat (2) cycle();
    check("all_blocked_idle", int'(sched_idle), 1);
    check("all_blocked_valid", int'(issue_valid), 0);
    block_clr = 1'b1; block_clr_hart = 3'd6;
    cycle();
    clear_pulses();
    check("clr6_still_idle", int'(issue_valid), 0);
    cycle();
    check("clr6_offer_valid", int'(issue_valid), 1);
    check("clr6_offer_hart", int'(issue_hart), 6);

    // Asynchronous reset in the middle of an offer
    issue_ready = 1'b0;
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_valid", int'(issue_valid), 0);
    check("async_blocked", int'(hart_blocked), 0);
    check("async_parked", int'(hart_parked), 0);
    check("async_idle", int'(sched_idle), 1);
    check("async_hart", int'(issue_hart), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hart_en = 8'hFF;
    issue_ready = 1'b1;
    cycle();
    check("rerelease_valid", int'(issue_valid), 1);
    check("rerelease_hart", int'(issue_hart), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      hart_en        = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
      issue_ready    = ($urandom_range(0, 3) != 0);
      block_set      = ($urandom_range(0, 3) == 0);
      block_set_hart = W'($urandom_range(0, N - 1));
      block_clr      = ($urandom_range(0, 2) == 0);
      block_clr_hart = W'($urandom_range(0, N - 1));
      trap_valid     = ($urandom_range(0, 7) == 0);
      trap_hart      = W'($urandom_range(0, N - 1));
      resume         = N'($urandom & $urandom & $urandom);
      cycle();
    end
    clear_pulses();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
